// File: rtl/keypad_scanner_pkg.sv
// Shared washer front-panel UI types: scanner FSM states, sweep classes,
// panel key codes and the sweep classification helper.
package washer_ui_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } sweep_cls_e;

  typedef struct packed {
    sweep_cls_e cls;
    logic [3:0] key;
  } sweep_res_t;

  localparam logic [3:0] KEY_START   = 4'd0;
  localparam logic [3:0] KEY_PAUSE   = 4'd1;
  localparam logic [3:0] KEY_PROG_UP = 4'd2;
  localparam logic [3:0] KEY_PROG_DN = 4'd3;
  localparam logic [3:0] KEY_TIME_UP = 4'd4;
  localparam logic [3:0] KEY_TIME_DN = 4'd5;

  // Bit i of closed is key code i; key is only meaningful for SINGLE.
  function automatic sweep_res_t classify_sweep(input logic [15:0] closed);
    sweep_res_t res;
    logic [4:0] n;
    n       = 5'd0;
    res.key = 4'd0;
    res.cls = NONE;
    for (int i = 0; i < 16; i++) begin
      if (closed[i]) begin
        n       = n + 5'd1;
        res.key = 4'(i);
      end else begin
        n = n;
      end
    end
    case (n)
      5'd0:    res.cls = NONE;
      5'd1:    res.cls = SINGLE;
      default: res.cls = MULTI;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the accepted-key outputs toward the control FSM.
interface keypad_scanner_if #(
  parameter int COLS = 4,
  parameter int ROWS = 4
);
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_sel;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_held;

  modport master (output row_in, input col_sel, key_code, key_valid, key_held);
  modport slave  (input row_in, output col_sel, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_col_driver.sv
// Column strobe sequencer: dwells on each column, snapshots the closures of a
// whole sweep and presents the classified sweep with a one-cycle sweep_done.
module keypad_col_driver
  import washer_ui_pkg::*;
#(
  parameter int COLS  = 4,
  parameter int ROWS  = 4,
  parameter int DWELL = 2
) (
  input  logic            qclock,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_sel,
  output logic            sweep_done,
  output sweep_cls_e      sweep_cls,
  output logic [3:0]      sweep_key
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CW = $clog2(COLS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  logic [DW-1:0]   dwell_r;
  logic [CW-1:0]   col_r;
  logic [COLS-1:0] col_sel_r;
  logic [15:0]     snap_r;
  logic [15:0]     merged_s;
  sweep_res_t      res_s;
  logic            sweep_done_r;
  sweep_cls_e      cls_r;
  logic [3:0]      key_r;

  // Snapshot with the currently driven column's rows folded in.
  always_comb begin
    merged_s = snap_r;
    for (int r = 0; r < ROWS; r++) begin
      merged_s[4'(r * COLS) + 4'(col_r)] = ~row_in[r];
    end
    res_s = classify_sweep(merged_s);
  end

  // Dwell/column counters, strobe rotation, snapshot capture and sweep result.
  always_ff @(posedge qclock) begin
    if (!rst_n) begin
      dwell_r      <= '0;
      col_r        <= '0;
      col_sel_r    <= {{(COLS-1){1'b1}}, 1'b0};
      snap_r       <= 16'd0;
      sweep_done_r <= 1'b0;
      cls_r        <= NONE;
      key_r        <= 4'd0;
    end else begin
      sweep_done_r <= 1'b0;
      if (dwell_r == DWELL_LAST) begin
        dwell_r   <= '0;
        col_sel_r <= {col_sel_r[COLS-2:0], col_sel_r[COLS-1]};
        if (col_r == COL_LAST) begin
          col_r        <= '0;
          snap_r       <= 16'd0;
          sweep_done_r <= 1'b1;
          cls_r        <= res_s.cls;
          key_r        <= res_s.key;
        end else begin
          col_r  <= col_r + CW'(1);
          snap_r <= merged_s;
        end
      end else begin
        dwell_r <= dwell_r + DW'(1);
      end
    end
  end

  assign col_sel    = col_sel_r;
  assign sweep_done = sweep_done_r;
  assign sweep_cls  = cls_r;
  assign sweep_key  = key_r;

endmodule

// File: rtl/keypad_scanner.sv
// Washer front-panel keypad scanner: column sweep plus a sweep-granular
// press/release debounce FSM producing key_code, key_valid and key_held.
module keypad_scanner
  import washer_ui_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int DWELL    = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic qclock,
  input  logic rst_n,
  keypad_scanner_if.slave kp
);

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic       sweep_done_s;
  sweep_cls_e sweep_cls_s;
  logic [3:0] sweep_key_s;
  logic       is_single_s;

  kp_state_e  state_r;
  logic [3:0] cand_r;
  logic [3:0] cnt_r;
  logic [3:0] key_code_r;
  logic       key_valid_r;
  logic       key_held_r;

  keypad_col_driver #(.COLS(COLS), .ROWS(ROWS), .DWELL(DWELL)) u_col_driver (
    .qclock     (qclock),
    .rst_n      (rst_n),
    .row_in     (kp.row_in),
    .col_sel    (kp.col_sel),
    .sweep_done (sweep_done_s),
    .sweep_cls  (sweep_cls_s),
    .sweep_key  (sweep_key_s)
  );

  assign is_single_s = (sweep_cls_s == SINGLE);

  // Debounce FSM; advances once per completed sweep. MULTI is never accepted.
  always_ff @(posedge qclock) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cand_r      <= 4'd0;
      cnt_r       <= 4'd0;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (sweep_done_s) begin
        case (state_r)
          IDLE: begin
            if (is_single_s) begin
              cand_r <= sweep_key_s;
              if (DEBOUNCE == 1) begin
                state_r     <= PRESSED;
                cnt_r       <= 4'd0;
                key_code_r  <= sweep_key_s;
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
              end else begin
                state_r <= PRESS_DB;
                cnt_r   <= 4'd1;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          PRESS_DB: begin
            if (is_single_s && sweep_key_s == cand_r) begin
              if (cnt_r + 4'd1 >= DB) begin
                state_r     <= PRESSED;
                cnt_r       <= 4'd0;
                key_code_r  <= cand_r;
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
              end else begin
                cnt_r <= cnt_r + 4'd1;
              end
            end else if (is_single_s) begin
              cand_r <= sweep_key_s;
              cnt_r  <= 4'd1;
            end else begin
              state_r <= IDLE;
              cnt_r   <= 4'd0;
            end
          end
          PRESSED: begin
            if (is_single_s && sweep_key_s == key_code_r) begin
              cnt_r <= 4'd0;
            end else if (DEBOUNCE == 1) begin
              state_r    <= IDLE;
              cnt_r      <= 4'd0;
              key_held_r <= 1'b0;
            end else begin
              state_r <= REL_DB;
              cnt_r   <= 4'd1;
            end
          end
          REL_DB: begin
            if (is_single_s && sweep_key_s == key_code_r) begin
              state_r <= PRESSED;
              cnt_r   <= 4'd0;
            end else if (cnt_r + 4'd1 >= DB) begin
              state_r    <= IDLE;
              cnt_r      <= 4'd0;
              key_held_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a physical keypad model drives the rows,
// directed sweeps push expected key pulses, and a monitor pops them on key_valid.
`timescale 1ns/1ps
module tb_keypad_scanner;
  import washer_ui_pkg::*;

  logic        qclock = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] keys   = 16'd0;
  logic        force_low = 1'b1;
  int unsigned edge_no = 0;
  int unsigned sweep_idx = 0;
  int          total = 0;
  int          passed = 0;
  logic [3:0]  exp_code_q[$];
  int unsigned exp_edge_q[$];
  logic [3:0]  rot_tbl [8];

  always #5 qclock = ~qclock;

  keypad_scanner_if #(.COLS(4), .ROWS(4)) kp ();

  keypad_scanner #(.COLS(4), .ROWS(4), .DWELL(2), .DEBOUNCE(3)) dut (
    .qclock (qclock),
    .rst_n  (rst_n),
    .kp     (kp)
  );

  // Keypad matrix: a closed key pulls its row low while its column is strobed.
  always_comb begin
    kp.row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (kp.col_sel[c] == 1'b0 && keys[r*4 + c]) kp.row_in[r] = 1'b0;
      end
    end
    if (force_low) kp.row_in = 4'b0000;
  end

  always @(posedge qclock) begin
    if (!rst_n) edge_no <= 0;
    else        edge_no <= edge_no + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
  endtask

  // Monitor: every key_valid pulse must match the oldest expected press.
  always @(negedge qclock) begin
    if (kp.key_valid === 1'b1) begin
      if (exp_code_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: got key_valid=1 code %0d expected no pulse (edge %0d)",
                 kp.key_code, edge_no);
      end else begin
        check("pulse_code", 32'(kp.key_code), 32'(exp_code_q.pop_front()));
        check("pulse_edge", edge_no, exp_edge_q.pop_front());
        check("pulse_held", 32'(kp.key_held), 32'd1);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge qclock);
    @(negedge qclock) rst_n = 1'b1;
    @(posedge qclock);
    #1;
    sweep_idx = 0;
  endtask

  task automatic sweep(input logic [15:0] m);
    keys = m;
    repeat (8) @(posedge qclock);
    #1;
    sweep_idx++;
  endtask

  // Acceptance of sweep s shows key_valid after edge 8*s+1 since reset release.
  task automatic expect_key(input logic [3:0] code);
    exp_code_q.push_back(code);
    exp_edge_q.push_back(8 * sweep_idx + 1);
  endtask

  task automatic release_all();
    for (int i = 1; i <= 3; i++) begin
      sweep(16'd0);
      check("release_held", 32'(kp.key_held), (i < 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] bounce [6];
    logic [1:0] held_roll [4];
    rot_tbl   = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    bounce    = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
    held_roll = '{2'd1, 2'd1, 2'd0, 2'd0};

    // Reset values with every row pulled low
    repeat (3) @(posedge qclock);
    #1;
    check("rst_col_sel", 32'(kp.col_sel), 32'h0000_000e);
    check("rst_valid", 32'(kp.key_valid), 32'd0);
    check("rst_held", 32'(kp.key_held), 32'd0);
    check("rst_code", 32'(kp.key_code), 32'd0);
    @(negedge qclock) rst_n = 1'b1;
    check("rot_0", 32'(kp.col_sel), 32'(rot_tbl[0]));
    for (int i = 1; i < 8; i++) begin
      @(negedge qclock);
      check("rot", 32'(kp.col_sel), 32'(rot_tbl[i]));
    end
    force_low = 1'b0;
    keys = 16'd0;
    do_reset();

    // Clean press of row 1 / col 2
    for (int i = 1; i <= 5; i++) begin
      sweep(16'h0040);
      if (i == 3) expect_key(4'd6);
      check("clean_held", 32'(kp.key_held), (i >= 3) ? 32'd1 : 32'd0);
    end
    release_all();
    check("clean_code_kept", 32'(kp.key_code), 32'd6);

    // Bounce: a gap in sweep 3 restarts the count
    for (int i = 0; i < 6; i++) begin
      sweep(bounce[i] != 2'd0 ? 16'h0040 : 16'h0000);
      if (i == 5) expect_key(4'd6);
      check("bounce_held", 32'(kp.key_held), (i == 5) ? 32'd1 : 32'd0);
    end
    release_all();

    // Ghosting: two closures never accepted, then key 0 alone
    for (int i = 0; i < 6; i++) begin
      sweep(16'h0801);
      check("ghost_held", 32'(kp.key_held), 32'd0);
    end
    for (int i = 1; i <= 3; i++) begin
      sweep(16'h0001);
      if (i == 3) expect_key(KEY_START);
      check("ghost_key0_held", 32'(kp.key_held), (i == 3) ? 32'd1 : 32'd0);
    end
    release_all();

    // Rollover: key 5 held, key 9 added, key 5 released
    for (int i = 1; i <= 3; i++) sweep(16'h0020);
    expect_key(KEY_TIME_DN);
    check("roll_5_held", 32'(kp.key_held), 32'd1);
    for (int i = 0; i < 4; i++) begin
      sweep(16'h0220);
      check("roll_multi_held", 32'(kp.key_held), 32'(held_roll[i]));
    end
    for (int i = 1; i <= 3; i++) begin
      sweep(16'h0200);
      if (i == 3) expect_key(4'd9);
      check("roll_9_held", 32'(kp.key_held), (i == 3) ? 32'd1 : 32'd0);
    end
    check("roll_code", 32'(kp.key_code), 32'd9);
    release_all();

    // Reset mid-press discards two qualifying sweeps
    for (int i = 0; i < 2; i++) sweep(16'h0040);
    do_reset();
    check("midrst_held", 32'(kp.key_held), 32'd0);
    check("midrst_code", 32'(kp.key_code), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      sweep(16'h0040);
      if (i == 3) expect_key(4'd6);
      check("midrst_press_held", 32'(kp.key_held), (i == 3) ? 32'd1 : 32'd0);
    end
    release_all();

    repeat (4) @(posedge qclock);
    #1;
    check("queue_drained", 32'(exp_code_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
